hbif_cmd_parser: RTL and testbench

Byte-level command parser sitting between the UART receiver and the UART transmitter of the host bus interface. It consumes received bytes, decodes fixed-length read/write frames, executes one register access on a simple request/acknowledge bus, and returns a one-byte response to the transmitter. It replaces the direct RX-to-TX loopback path at the top level.

---
 rtl/hbif_cmd_parser.sv | 209 ++++++++++++++++++++
 tb/tb_hbif_cmd_parser.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbif_cmd_parser.sv
// ---------------------------------------------------------------------------
// hbif_cmd_parser
//
// Byte-level command parser between the UART receiver and transmitter of the
// host bus interface. Decodes fixed-length frames, performs one register
// access on a req/ack bus and returns a single response byte.
//
//   Write frame : 0x57, addr, data -> bus write -> response 0x06
//   Read frame  : 0x52, addr       -> bus read  -> response = read data
//   Unknown cmd : any other byte   -> response 0x15, err pulse
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   en_i                   parser enable (gates the start of new frames only)
//   rx_data_valid_i/_i     received byte strobe and data
//   tx_data_ready_i        transmitter ready
//   tx_data_valid_o/_o     response byte valid and data
//   bus_req_o/_we_o        bus request and direction (1 = write)
//   bus_addr_o/_wdata_o    bus address and write data
//   bus_ack_i/_rdata_i     bus completion and read data
//   err_o                  one-cycle error pulse (bad cmd, overrun, timeout)
//
// States
//   state  | meaning
//   IDLE   | waiting for a command byte
//   ADDR   | command latched, waiting for the address byte
//   DATA   | write only: waiting for the data byte
//   BUS    | bus request outstanding, waiting for ack
//   RESP   | response byte presented, waiting for tx handshake
// ---------------------------------------------------------------------------
module hbif_cmd_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic       rx_data_valid_i,
  input  logic [7:0] rx_data_i,
  input  logic       tx_data_ready_i,
  output logic       tx_data_valid_o,
  output logic [7:0] tx_data_o,
  output logic       bus_req_o,
  output logic       bus_we_o,
  output logic [7:0] bus_addr_o,
  output logic [7:0] bus_wdata_o,
  input  logic       bus_ack_i,
  input  logic [7:0] bus_rdata_i,
  output logic       err_o
);

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

  // The counter never needs to hold more than TIMEOUT_CYCLES-2: the expiry is
  // decided one cycle early so that err_o and the return to IDLE are both
  // registered and land TIMEOUT_CYCLES cycles after the last byte.
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_BUS  = 3'd3,
    S_RESP = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_valid_q, tx_valid_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [7:0]       bus_addr_q, bus_addr_d;
  logic [7:0]       bus_wdata_q, bus_wdata_d;
  logic             err_q, err_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cmd_wr_q    <= 1'b0;
      cnt_q       <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 8'h00;
      bus_wdata_q <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      cnt_q       <= cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    cnt_d       = cnt_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rx_data_valid_i && en_i) begin
          if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
            cmd_wr_d = (rx_data_i == CMD_WR);
            state_d  = S_ADDR;
          end else begin
            tx_data_d  = RSP_NAK;
            tx_valid_d = 1'b1;
            err_d      = 1'b1;
            state_d    = S_RESP;
          end
        end
      end

      S_ADDR: begin
        // A byte arriving in the expiry cycle wins over the timeout.
        if (rx_data_valid_i) begin
          bus_addr_d = rx_data_i;
          cnt_d      = '0;
          if (cmd_wr_q) begin
            state_d = S_DATA;
          end else begin
            bus_req_d = 1'b1;
            bus_we_d  = 1'b0;
            state_d   = S_BUS;
          end
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (rx_data_valid_i) begin
          bus_wdata_d = rx_data_i;
          cnt_d       = '0;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b1;
          state_d     = S_BUS;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_BUS: begin
        if (rx_data_valid_i) begin
          err_d = 1'b1;
        end
        if (bus_ack_i) begin
          bus_req_d  = 1'b0;
          bus_we_d   = 1'b0;
          tx_data_d  = cmd_wr_q ? RSP_ACK : bus_rdata_i;
          tx_valid_d = 1'b1;
          state_d    = S_RESP;
        end
      end

      S_RESP: begin
        if (rx_data_valid_i) begin
          err_d = 1'b1;
        end
        if (tx_data_ready_i) begin
          tx_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_data_valid_o = tx_valid_q;
  assign tx_data_o       = tx_data_q;
  assign bus_req_o       = bus_req_q;
  assign bus_we_o        = bus_we_q;
  assign bus_addr_o      = bus_addr_q;
  assign bus_wdata_o     = bus_wdata_q;
  assign err_o           = err_q;

endmodule

// File: tb/tb_hbif_cmd_parser.sv
// ---------------------------------------------------------------------------
// tb_hbif_cmd_parser
//
// Self-checking bench for hbif_cmd_parser. Inputs are driven 1 ns after the
// rising edge and outputs are sampled at the same point, so a value driven in
// cycle T is seen on the registered outputs in cycle T+1.
// ---------------------------------------------------------------------------
module tb_hbif_cmd_parser;

  localparam int unsigned TO = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       rxv;
  logic [7:0] rxd;
  logic       txr;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       req;
  logic       we;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       err;

  int n_pass = 0;
  int n_chk  = 0;
  int err_cnt = 0;
  int req_cnt = 0;

  hbif_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .en_i            (en),
    .rx_data_valid_i (rxv),
    .rx_data_i       (rxd),
    .tx_data_ready_i (txr),
    .tx_data_valid_o (tx_valid),
    .tx_data_o       (tx_data),
    .bus_req_o       (req),
    .bus_we_o        (we),
    .bus_addr_o      (addr),
    .bus_wdata_o     (wdata),
    .bus_ack_i       (ack),
    .bus_rdata_i     (rdata),
    .err_o           (err)
  );

  always #5 clk = ~clk;

  // Count cycles in which err_o / bus_req_o were high.
  always @(posedge clk) begin
    if (err) err_cnt++;
    if (req) req_cnt++;
  end

  typedef struct {
    string      name;
    logic       wr;
    logic [7:0] a;
    logic [7:0] d;
    int         ack_dly;
    logic [7:0] rd;
    logic [7:0] exp_resp;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rxv = 1'b1;
    rxd = b;
    tick();
    rxv = 1'b0;
    rxd = 8'h00;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, ".tx_valid"}, tx_valid, 0);
    chk({nm, ".tx_data"},  tx_data,  0);
    chk({nm, ".req"},      req,      0);
    chk({nm, ".we"},       we,       0);
    chk({nm, ".addr"},     addr,     0);
    chk({nm, ".wdata"},    wdata,    0);
    chk({nm, ".err"},      err,      0);
  endtask

  task automatic handshake(input string nm);
    txr = 1'b1;
    tick();
    txr = 1'b0;
    chk({nm, ".tx_done"}, tx_valid, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int e0;
    e0 = err_cnt;
    send_byte(v.wr ? 8'h57 : 8'h52);
    send_byte(v.a);
    if (v.wr) send_byte(v.d);
    chk({v.name, ".req"},  req,  1);
    chk({v.name, ".we"},   we,   {31'd0, v.wr});
    chk({v.name, ".addr"}, addr, {24'd0, v.a});
    if (v.wr) chk({v.name, ".wdata"}, wdata, {24'd0, v.d});
    for (int i = 0; i < v.ack_dly; i++) tick();
    if (v.ack_dly > 0) chk({v.name, ".req_hold"}, {req, addr}, {1'b1, v.a});
    ack   = 1'b1;
    rdata = v.rd;
    tick();
    ack   = 1'b0;
    rdata = 8'h00;
    chk({v.name, ".req_drop"}, req, 0);
    chk({v.name, ".tx_valid"}, tx_valid, 1);
    chk({v.name, ".resp"}, tx_data, {24'd0, v.exp_resp});
    handshake(v.name);
    chk({v.name, ".no_err"}, err_cnt - e0, 0);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    vec_t rd_after;
    int   e0, r0;
    logic [7:0] held;
    logic stable;

    vecs[0] = '{"wr_10_a5", 1'b1, 8'h10, 8'hA5, 2, 8'h00, 8'h06};
    vecs[1] = '{"rd_3c",    1'b0, 8'h3C, 8'h00, 0, 8'h5A, 8'h5A};
    vecs[2] = '{"wr_ff_00", 1'b1, 8'hFF, 8'h00, 0, 8'h33, 8'h06};
    vecs[3] = '{"rd_00",    1'b0, 8'h00, 8'h00, 3, 8'hC3, 8'hC3};
    vecs[4] = '{"wr_80_7e", 1'b1, 8'h80, 8'h7E, 1, 8'h00, 8'h06};

    rst = 1'b1; en = 1'b1; rxv = 1'b0; rxd = 8'h00;
    txr = 1'b0; ack = 1'b0; rdata = 8'h00;
    tick();
    tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Unknown command: NAK and a single err pulse, no bus access.
    r0 = req_cnt;
    send_byte(8'h41);
    chk("nak.err",      err,      1);
    chk("nak.tx_valid", tx_valid, 1);
    chk("nak.data",     tx_data,  8'h15);
    chk("nak.req",      req,      0);
    tick();
    chk("nak.err_once", err, 0);
    handshake("nak");
    chk("nak.no_bus", req_cnt - r0, 0);

    // Inter-byte timeout: err exactly TO cycles after the address byte.
    r0 = req_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    for (int i = 0; i < int'(TO) - 2; i++) tick();
    chk("to.err_early", err, 0);
    tick();
    chk("to.err", err, 1);
    tick();
    chk("to.err_once", err, 0);
    chk("to.no_bus", req_cnt - r0, 0);
    chk("to.idle_tx", tx_valid, 0);
    rd_after = '{"rd_after_to", 1'b0, 8'h3C, 8'h00, 0, 8'h5A, 8'h5A};
    run_vec(rd_after);

    // Byte arriving in the expiry cycle counts; no timeout.
    e0 = err_cnt;
    send_byte(8'h57);
    send_byte(8'h22);
    for (int i = 0; i < int'(TO) - 2; i++) tick();
    send_byte(8'h99);
    chk("edge.err", err, 0);
    chk("edge.req", req, 1);
    chk("edge.wdata", wdata, 8'h99);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("edge.resp", tx_data, 8'h06);
    handshake("edge");
    chk("edge.no_err", err_cnt - e0, 0);

    // Overrun while the response waits on a stalled transmitter.
    send_byte(8'h52);
    send_byte(8'h20);
    ack = 1'b1; rdata = 8'h99;
    tick();
    ack = 1'b0; rdata = 8'h00;
    e0 = err_cnt;
    held = tx_data;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rxv = (i % 2 == 0);
      rxd = 8'h57;
      tick();
      if (tx_data !== held || tx_valid !== 1'b1) stable = 1'b0;
    end
    rxv = 1'b0;
    tick();
    tick();
    chk("ovr.stable", stable, 1);
    chk("ovr.data", tx_data, 8'h99);
    chk("ovr.err_count", err_cnt - e0, 10);
    handshake("ovr");
    tick();
    chk("ovr.single_xfer", tx_valid, 0);

    // Reset while a bus request is outstanding.
    send_byte(8'h57);
    send_byte(8'h44);
    send_byte(8'h55);
    chk("rst.req_before", req, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    tick();
    chk("rst.still_idle", {tx_valid, req}, 0);

    // Disabled parser ignores bytes without error.
    e0 = err_cnt;
    en = 1'b0;
    send_byte(8'h52);
    send_byte(8'h3C);
    tick();
    chk("dis.no_err", err_cnt - e0, 0);
    chk("dis.idle", {tx_valid, req}, 0);

    // Deasserting enable mid-frame does not abort the frame.
    en = 1'b1;
    send_byte(8'h52);
    en = 1'b0;
    send_byte(8'h77);
    chk("midframe.req", req, 1);
    chk("midframe.addr", addr, 8'h77);
    ack = 1'b1; rdata = 8'hE1;
    tick();
    ack = 1'b0;
    chk("midframe.resp", tx_data, 8'hE1);
    handshake("midframe");
    en = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
